// File: rtl/fir_pkg.sv
// Shared types and width helpers for the multi-channel FIR engine.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        HOLD
    } fir_state_t;

    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int addr_w(input int depth);
        return sel_w(depth);
    endfunction

    function automatic int acc_w(input int dw, input int cw, input int taps);
        return dw + cw + $clog2(taps);
    endfunction

endpackage

// File: rtl/fir_coeff_rom.sv
// Coefficient ROM, one-cycle synchronous read.
// First bank is 0.5 (Q1.x), remaining banks are max positive.
module fir_coeff_rom
  import fir_pkg::*;
#(
  parameter int    COEFF_W   = 16,
  parameter int    DEPTH     = 1021,
  parameter int    BANK_TAPS = DEPTH,
  parameter string INIT_FILE = ""
) (
  input  logic                     clk,
  input  logic [addr_w(DEPTH)-1:0] addr,
  output logic [COEFF_W-1:0]       dout
);

  localparam int AW = addr_w(DEPTH);

  localparam logic [AW-1:0] SPLIT =
    AW'(BANK_TAPS);
  localparam logic [COEFF_W-1:0] HALF =
    COEFF_W'(1) << (COEFF_W - 2);
  localparam logic [COEFF_W-1:0] UNITY =
    {1'b0, {(COEFF_W - 1){1'b1}}};

  always_ff @(posedge clk) begin
    dout <= (addr < SPLIT) ? HALF : UNITY;
  end

endmodule

// File: rtl/fir_multi_ch.sv
// N-channel FIR convolution engine with banked coefficients.
// Define FIR_SAT_EN for a saturating output stage (default wraps).
module fir_multi_ch
    import fir_pkg::*;
#(
    parameter int    NUM_CH     = 2,
    parameter int    DATA_W     = 16,
    parameter int    COEFF_W    = 16,
    parameter int    NUM_TAPS   = 1021,
    parameter int    NUM_BANKS  = 1,
    parameter int    FRAC_SHIFT = 15,
    parameter string INIT_FILE  = ""
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          sequencing,
    input  logic [NUM_CH*DATA_W-1:0]      smpl_in,
    input  logic [sel_w(NUM_BANKS)-1:0]   bank_sel,
    output logic [NUM_CH*DATA_W-1:0]      smpl_out,
    output logic                          out_vld,
    output logic                          busy,
    output logic                          short_err
);

    localparam int ACC_W = acc_w(DATA_W, COEFF_W, NUM_TAPS);
    localparam int PW    = DATA_W + COEFF_W;
    localparam int DEPTH = NUM_BANKS * NUM_TAPS;
    localparam int AW    = addr_w(DEPTH);
    localparam int BW    = sel_w(NUM_BANKS);
    localparam int TW    = sel_w(NUM_TAPS);
    localparam logic [TW-1:0] LAST = TW'(NUM_TAPS - 1);

    fir_state_t state, state_nxt;

    logic [AW-1:0]            addr, rom_addr, base;
    logic [BW-1:0]            bank_eff;
    logic [TW-1:0]            tap_cnt;
    logic [COEFF_W-1:0]       coeff;
    logic signed [ACC_W-1:0]  acc     [NUM_CH];
    logic signed [ACC_W-1:0]  acc_nxt [NUM_CH];
    logic signed [PW-1:0]     prod    [NUM_CH];
    logic [NUM_CH*DATA_W-1:0] out_nxt;
    logic start, acc_en, last, abort, clr_addr;

`ifdef FIR_SAT_EN
    localparam logic signed [ACC_W-1:0] SMAX =
        (ACC_W'(1) <<< (DATA_W - 1)) - ACC_W'(1);
    localparam logic signed [ACC_W-1:0] SMIN = -SMAX - ACC_W'(1);
    logic signed [ACC_W-1:0] shifted [NUM_CH];
`endif

    // The setup cycle must already address tap 0 of the selected bank.
    always_comb begin
        bank_eff = (32'(bank_sel) < NUM_BANKS) ? bank_sel : '0;
        base     = AW'(32'(bank_eff) * NUM_TAPS);
        rom_addr = (state == IDLE) ? base : addr;
    end

    fir_coeff_rom #(
        .COEFF_W   (COEFF_W),
        .DEPTH     (DEPTH),
        .BANK_TAPS (NUM_TAPS),
        .INIT_FILE (INIT_FILE)
    ) u_rom (
        .clk  (clk),
        .addr (rom_addr),
        .dout (coeff)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        acc_en    = 1'b0;
        last      = 1'b0;
        abort     = 1'b0;
        clr_addr  = 1'b0;
        unique case (state)
            IDLE: begin
                if (sequencing) begin
                    start     = 1'b1;
                    state_nxt = CONV;
                end
            end
            CONV: begin
                if (sequencing) begin
                    acc_en = 1'b1;
                    if (tap_cnt == LAST) begin
                        last      = 1'b1;
                        state_nxt = HOLD;
                    end
                end else begin
                    abort     = 1'b1;
                    clr_addr  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            HOLD: begin
                if (!sequencing) begin
                    clr_addr  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        out_nxt = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            prod[c] = PW'($signed(smpl_in[c*DATA_W +: DATA_W]))
                    * PW'($signed(coeff));
            acc_nxt[c] = acc[c] + ACC_W'(prod[c]);
`ifdef FIR_SAT_EN
            shifted[c] = acc_nxt[c] >>> FRAC_SHIFT;
            if (shifted[c] > SMAX)
                out_nxt[c*DATA_W +: DATA_W] = SMAX[DATA_W-1:0];
            else if (shifted[c] < SMIN)
                out_nxt[c*DATA_W +: DATA_W] = SMIN[DATA_W-1:0];
            else
                out_nxt[c*DATA_W +: DATA_W] = shifted[c][DATA_W-1:0];
`else
            out_nxt[c*DATA_W +: DATA_W] = acc_nxt[c][FRAC_SHIFT +: DATA_W];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr      <= '0;
            tap_cnt   <= '0;
            smpl_out  <= '0;
            out_vld   <= 1'b0;
            short_err <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) acc[c] <= '0;
        end else begin
            out_vld   <= last;
            short_err <= abort;
            if (start) begin
                tap_cnt <= '0;
                addr    <= base + AW'(1);
                for (int c = 0; c < NUM_CH; c++) acc[c] <= '0;
            end
            if (acc_en) begin
                for (int c = 0; c < NUM_CH; c++) acc[c] <= acc_nxt[c];
                if (!last) begin
                    tap_cnt <= tap_cnt + TW'(1);
                    addr    <= addr + AW'(1);
                end
            end
            if (last) smpl_out <= out_nxt;
            if (clr_addr) addr <= '0;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_fir_multi_ch.sv
// Randomised self-checking bench for fir_multi_ch (4 taps, 2 ch, 2 banks).
module tb_fir_multi_ch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sequencing;
    logic [31:0] smpl_in;
    logic [0:0]  bank_sel;
    logic [31:0] smpl_out;
    logic        out_vld;
    logic        busy;
    logic        short_err;

    int checks = 0;
    int errors = 0;

    logic signed [15:0] tap_s [2][4];
    int          vld_cnt, vld_at, err_cnt;
    logic        busy_all, busy_tail;
    logic [31:0] got;

    always #5 clk = ~clk;

    fir_multi_ch #(
        .NUM_CH     (2),
        .DATA_W     (16),
        .COEFF_W    (16),
        .NUM_TAPS   (4),
        .NUM_BANKS  (2),
        .FRAC_SHIFT (15),
        .INIT_FILE  ("")
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sequencing (sequencing),
        .smpl_in    (smpl_in),
        .bank_sel   (bank_sel),
        .smpl_out   (smpl_out),
        .out_vld    (out_vld),
        .busy       (busy),
        .short_err  (short_err)
    );

    // Reference: dot product of the tap samples with the bank coefficient.
    function automatic logic [31:0] model(input int bank);
        logic [31:0] r;
        longint coef, sum, sh;
        coef = (bank == 1) ? 64'sd32767 : 64'sd16384;
        r = '0;
        for (int c = 0; c < 2; c++) begin
            sum = 0;
            for (int t = 0; t < 4; t++)
                sum += longint'(tap_s[c][t]) * coef;
            sh = sum >>> 15;
`ifdef FIR_SAT_EN
            if (sh > 32767) sh = 32767;
            if (sh < -32768) sh = -32768;
`endif
            r[c*16 +: 16] = sh[15:0];
        end
        return r;
    endfunction

    task automatic fill_const(input logic [15:0] a, input logic [15:0] b);
        for (int t = 0; t < 4; t++) begin
            tap_s[0][t] = a;
            tap_s[1][t] = b;
        end
    endtask

    task automatic fill_rand();
        for (int c = 0; c < 2; c++)
            for (int t = 0; t < 4; t++)
                tap_s[c][t] = 16'($urandom);
    endtask

    task automatic sample(input int k);
        @(posedge clk);
        #1;
        if (out_vld) begin
            vld_cnt++;
            if (vld_at < 0) vld_at = k + 1;
            got = smpl_out;
        end
        if (short_err) err_cnt++;
    endtask

    task automatic burst(input int ncyc, input int b0, input int b1,
                         input int sw_at);
        vld_cnt  = 0;
        vld_at   = -1;
        err_cnt  = 0;
        busy_all = 1'b1;
        got      = 'x;
        for (int k = 0; k < ncyc; k++) begin
            sequencing = 1'b1;
            bank_sel   = (k >= sw_at) ? 1'(b1) : 1'(b0);
            if (k >= 1 && k <= 4)
                smpl_in = {tap_s[1][k-1], tap_s[0][k-1]};
            else
                smpl_in = $urandom;
            sample(k);
            if (!busy) busy_all = 1'b0;
        end
        sequencing = 1'b0;
        smpl_in    = $urandom;
        sample(ncyc);
        busy_tail = busy;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        sequencing = 1'b0;
        smpl_in    = '0;
        bank_sel   = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (smpl_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_out got %h want 0", smpl_out);
        end
        checks++;
        if (out_vld !== 1'b0 || busy !== 1'b0 || short_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got vld=%b busy=%b err=%b want 0 0 0",
                     out_vld, busy, short_err);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        fill_const(16'h1000, 16'hF000);
        burst(5, 0, 0, 0);
        checks++;
        if (vld_cnt !== 1 || vld_at !== 5) begin
            errors++;
            $display("FAIL basic_vld got cnt=%0d at=%0d want 1 at 5",
                     vld_cnt, vld_at);
        end
        checks++;
        if (got !== 32'hE000_2000 || got !== model(0)) begin
            errors++;
            $display("FAIL basic_out got %h want %h", got, 32'hE000_2000);
        end
        checks++;
        if (err_cnt !== 0 || busy_tail !== 1'b0) begin
            errors++;
            $display("FAIL basic_err got err=%0d busy=%b want 0 0",
                     err_cnt, busy_tail);
        end
    endtask

    task automatic test_bank1();
        logic [31:0] exp;
`ifdef FIR_SAT_EN
        exp = 32'h7FFF_7FFF;
`else
        exp = 32'hFFF8_FFF8;
`endif
        fill_const(16'h7FFF, 16'h7FFF);
        burst(5, 1, 1, 0);
        checks++;
        if (vld_cnt !== 1 || got !== exp) begin
            errors++;
            $display("FAIL bank1_out got %h (vld %0d) want %h",
                     got, vld_cnt, exp);
        end
    endtask

    task automatic test_short();
        logic [31:0] prev;
        prev = smpl_out;
        fill_rand();
        burst(3, 0, 0, 0);
        checks++;
        if (err_cnt !== 1 || vld_cnt !== 0) begin
            errors++;
            $display("FAIL short_pulse got err=%0d vld=%0d want 1 0",
                     err_cnt, vld_cnt);
        end
        checks++;
        if (smpl_out !== prev || busy_tail !== 1'b0) begin
            errors++;
            $display("FAIL short_hold got %h busy=%b want %h busy=0",
                     smpl_out, busy_tail, prev);
        end
        @(posedge clk);
        #1;
        checks++;
        if (short_err !== 1'b0) begin
            errors++;
            $display("FAIL short_once got %b want 0", short_err);
        end
    endtask

    task automatic test_long();
        fill_const(16'h1000, 16'hF000);
        burst(8, 0, 0, 0);
        checks++;
        if (vld_cnt !== 1 || vld_at !== 5) begin
            errors++;
            $display("FAIL long_vld got cnt=%0d at=%0d want 1 at 5",
                     vld_cnt, vld_at);
        end
        checks++;
        if (busy_all !== 1'b1 || busy_tail !== 1'b0 || err_cnt !== 0) begin
            errors++;
            $display("FAIL long_busy got all=%b tail=%b err=%0d want 1 0 0",
                     busy_all, busy_tail, err_cnt);
        end
        checks++;
        if (got !== model(0)) begin
            errors++;
            $display("FAIL long_out got %h want %h", got, model(0));
        end
    endtask

    task automatic test_bank_switch();
        fill_rand();
        burst(5, 0, 1, 2);
        checks++;
        if (vld_cnt !== 1 || got !== model(0)) begin
            errors++;
            $display("FAIL bswitch_first got %h want %h", got, model(0));
        end
        fill_rand();
        burst(5, 1, 1, 0);
        checks++;
        if (vld_cnt !== 1 || got !== model(1)) begin
            errors++;
            $display("FAIL bswitch_next got %h want %h", got, model(1));
        end
    endtask

    task automatic test_reset_mid();
        fill_rand();
        err_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            sequencing = 1'b1;
            bank_sel   = 1'b0;
            smpl_in    = (k == 0) ? $urandom : {tap_s[1][k-1], tap_s[0][k-1]};
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (smpl_out !== 32'h0 || out_vld !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_out got %h vld=%b want 0 0", smpl_out, out_vld);
        end
        checks++;
        if (busy !== 1'b0 || short_err !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_flags got busy=%b err=%b want 0 0",
                     busy, short_err);
        end
        rst_n      = 1'b1;
        sequencing = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (short_err !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_noerr got %b want 0", short_err);
        end
        fill_rand();
        burst(5, 0, 0, 0);
        checks++;
        if (vld_cnt !== 1 || got !== model(0) || err_cnt !== 0) begin
            errors++;
            $display("FAIL rstmid_fresh got %h vld=%0d want %h vld=1",
                     got, vld_cnt, model(0));
        end
    endtask

    task automatic test_random();
        int bank;
        for (int i = 0; i < 8; i++) begin
            fill_rand();
            bank = int'($urandom_range(0, 1));
            burst(5 + int'($urandom_range(0, 2)), bank, bank, 0);
            checks++;
            if (vld_cnt !== 1 || vld_at !== 5 || got !== model(bank)) begin
                errors++;
                $display("FAIL random_%0d got %h at=%0d want %h at 5",
                         i, got, vld_at, model(bank));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bank1();
        test_short();
        test_long();
        test_bank_switch();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
